// File: rtl/l2_fill_responder.sv
// Next-level memory model answering I/D L1 line fills after a fixed latency.
// Both L1 sides share one request engine with round-robin arbitration.
//
// state | meaning
// IDLE  | no request in flight; arbitrate between i_req and d_req
// WAIT  | request latched; latency counter running down
// RESP  | one-cycle valid pulse with the fill line on the served side
module l2_fill_responder #(
   parameter int LATENCY     = 4,
   parameter int LINE_BITS   = 512,
   parameter int OFFSET_BITS = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_req,
   input  logic [31:0]          i_add,
   output logic                 i_valid,
   output logic [LINE_BITS-1:0] i_data,
   input  logic                 d_req,
   input  logic [31:0]          d_add,
   output logic                 d_valid,
   output logic [LINE_BITS-1:0] d_data,
   output logic                 busy,
   output logic [31:0]          i_fills,
   output logic [31:0]          d_fills
);

   localparam int          WORDS     = LINE_BITS / 32;
   localparam logic [7:0]  CNT_LOAD  = 8'(LATENCY - 1);
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic        sel_d;
   logic        rr_last_d;
   logic [31:0] line_add;

   logic        pick_d;
   logic [31:0] accept_add;
   logic        fire;
   logic        fire_d;
   logic [31:0] fire_add;

   function automatic logic [LINE_BITS-1:0] line_pattern(input logic [31:0] base);
      logic [LINE_BITS-1:0] line;
      line = '0;
      for (int k = 0; k < WORDS; k++) begin
         line[32*k +: 32] = base + 32'(4 * k);
      end
      return line;
   endfunction

   // On a tie the side that was not served last wins.
   assign pick_d     = d_req & (~i_req | ~rr_last_d);
   assign accept_add = (pick_d ? d_add : i_add) & ADDR_MASK;

   // fire marks the edge that moves the engine into RESP.
   always_comb begin
      fire     = 1'b0;
      fire_d   = sel_d;
      fire_add = line_add;
      if (state == IDLE) begin
         fire     = (i_req | d_req) & (LATENCY == 1);
         fire_d   = pick_d;
         fire_add = accept_add;
      end else if (state == WAIT) begin
         fire     = (cnt <= 8'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_d     <= 1'b0;
         rr_last_d <= 1'b1;
         line_add  <= '0;
         i_valid   <= 1'b0;
         d_valid   <= 1'b0;
         i_data    <= '0;
         d_data    <= '0;
         busy      <= 1'b0;
         i_fills   <= '0;
         d_fills   <= '0;
      end else begin
         i_valid <= 1'b0;
         d_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  sel_d    <= pick_d;
                  line_add <= accept_add;
                  cnt      <= CNT_LOAD;
                  busy     <= (LATENCY > 1);
                  state    <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 8'd1;
               if (cnt <= 8'd1) begin
                  busy  <= 1'b0;
                  state <= RESP;
               end
            end
            RESP: begin
               if (sel_d) d_fills <= d_fills + 32'd1;
               else       i_fills <= i_fills + 32'd1;
               rr_last_d <= sel_d;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Only the served side's data register is rewritten.
         if (fire) begin
            if (fire_d) begin
               d_valid <= 1'b1;
               d_data  <= line_pattern(fire_add);
            end else begin
               i_valid <= 1'b1;
               i_data  <= line_pattern(fire_add);
            end
         end
      end
   end

endmodule

// File: tb/tb_l2_fill_responder.sv
// Directed bench for l2_fill_responder: a LATENCY=4 instance for the main
// vectors and corner sequences, and a LATENCY=1 instance for the short path.
module tb_l2_fill_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         i_req, d_req, i_valid, d_valid, busy;
   logic [31:0]  i_add, d_add, i_fills, d_fills;
   logic [511:0] i_data, d_data;

   logic         i_req1, d_req1, i_valid1, d_valid1, busy1;
   logic [31:0]  i_add1, d_add1, i_fills1, d_fills1;
   logic [511:0] i_data1, d_data1;

   l2_fill_responder #(.LATENCY(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_add(i_add), .i_valid(i_valid), .i_data(i_data),
      .d_req(d_req), .d_add(d_add), .d_valid(d_valid), .d_data(d_data),
      .busy(busy), .i_fills(i_fills), .d_fills(d_fills)
   );

   l2_fill_responder #(.LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req1), .i_add(i_add1), .i_valid(i_valid1), .i_data(i_data1),
      .d_req(d_req1), .d_add(d_add1), .d_valid(d_valid1), .d_data(d_data1),
      .busy(busy1), .i_fills(i_fills1), .d_fills(d_fills1)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until either valid on u4 is seen or the bound expires.
   task automatic wait_fill(input int bound, output int k, output logic busy_k1);
      k = 0;
      busy_k1 = 1'b0;
      while (k < bound) begin
         step();
         k++;
         if (k == 1) busy_k1 = busy;
         if (i_valid || d_valid) break;
      end
   endtask

   typedef struct {
      logic        ireq;
      logic        dreq;
      logic [31:0] iadd;
      logic [31:0] dadd;
      logic        exp_d;
      logic [31:0] w0;
      logic [31:0] w15;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int   k;
      int   seen;
      logic b1;
      logic [31:0] iexp, dexp;
      logic [5:0]  order;
      int   nserved;

      vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,          1'b0, 32'h0000_1200, 32'h0000_123C};
      vecs[1] = '{1'b0, 1'b1, 32'h0,          32'h0000_2000, 1'b1, 32'h0000_2000, 32'h0000_203C};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_2000, 1'b0, 32'h0000_0100, 32'h0000_013C};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0040, 32'hABCD_EF7F, 1'b1, 32'hABCD_EF40, 32'hABCD_EF7C};
      vecs[4] = '{1'b0, 1'b1, 32'h0,          32'hFFFF_FFC4, 1'b1, 32'hFFFF_FFC0, 32'hFFFF_FFFC};
      vecs[5] = '{1'b1, 1'b0, 32'h8000_003F, 32'h0,          1'b0, 32'h8000_0000, 32'h8000_003C};

      rst_n = 1'b0;
      i_req = 0; d_req = 0; i_add = 0; d_add = 0;
      i_req1 = 0; d_req1 = 0; i_add1 = 0; d_add1 = 0;
      step(); step();
      check("rst i_valid", 32'(i_valid), 0);
      check("rst d_valid", 32'(d_valid), 0);
      check("rst busy", 32'(busy), 0);
      check("rst i_data", i_data[31:0] | i_data[511:480], 0);
      check("rst d_data", d_data[31:0] | d_data[511:480], 0);
      check("rst i_fills", i_fills, 0);
      check("rst d_fills", d_fills, 0);
      check("rst l1 d_valid", 32'(d_valid1), 0);
      rst_n = 1'b1;
      step();

      // First tie after reset goes to I; D follows LATENCY+1 cycles later.
      i_req = 1; i_add = 32'h100; d_req = 1; d_add = 32'h2000;
      wait_fill(20, k, b1);
      check("tie lat", 32'(k), 4);
      check("tie i first", 32'(i_valid), 1);
      check("tie d quiet", 32'(d_valid), 0);
      check("tie i w0", i_data[31:0], 32'h100);
      i_req = 0;
      wait_fill(20, k, b1);
      check("tie d gap", 32'(k), 5);
      check("tie d valid", 32'(d_valid), 1);
      check("tie d w1", d_data[63:32], 32'h2004);
      d_req = 0;
      step();
      iexp = 1; dexp = 1;
      check("tie i_fills", i_fills, iexp);
      check("tie d_fills", d_fills, dexp);

      for (int v = 0; v < 6; v++) begin
         i_req = vecs[v].ireq; d_req = vecs[v].dreq;
         i_add = vecs[v].iadd; d_add = vecs[v].dadd;
         wait_fill(20, k, b1);
         check($sformatf("v%0d lat", v), 32'(k), 4);
         check($sformatf("v%0d busy", v), 32'(b1), 1);
         check($sformatf("v%0d busy resp", v), 32'(busy), 0);
         check($sformatf("v%0d i_valid", v), 32'(i_valid), 32'(!vecs[v].exp_d));
         check($sformatf("v%0d d_valid", v), 32'(d_valid), 32'(vecs[v].exp_d));
         if (vecs[v].exp_d) begin
            check($sformatf("v%0d w0", v), d_data[31:0], vecs[v].w0);
            check($sformatf("v%0d w15", v), d_data[511:480], vecs[v].w15);
            dexp++;
         end else begin
            check($sformatf("v%0d w0", v), i_data[31:0], vecs[v].w0);
            check($sformatf("v%0d w15", v), i_data[511:480], vecs[v].w15);
            iexp++;
         end
         i_req = 0; d_req = 0;
         step();
         check($sformatf("v%0d pulse", v), 32'(i_valid | d_valid), 0);
         check($sformatf("v%0d i_fills", v), i_fills, iexp);
         check($sformatf("v%0d d_fills", v), d_fills, dexp);
      end

      // Round-robin: both sides keep re-requesting; expect I,D,I,D,I,D.
      rst_n = 0; step(); rst_n = 1; step();
      i_req = 1; d_req = 1; i_add = 32'h400; d_add = 32'h800;
      order = '0; nserved = 0;
      for (int c = 0; c < 200 && nserved < 6; c++) begin
         step();
         if (i_req == 0) i_req = 1;
         if (d_req == 0) d_req = 1;
         if (i_valid || d_valid) begin
            order[nserved] = d_valid;
            nserved++;
            if (d_valid) d_req = 0; else i_req = 0;
         end
      end
      i_req = 0; d_req = 0;
      step();
      check("rr served", 32'(nserved), 6);
      check("rr order", 32'(order), 32'b101010);
      check("rr i_fills", i_fills, 3);
      check("rr d_fills", d_fills, 3);
      step();

      // Reset during WAIT abandons the request.
      i_req = 1; i_add = 32'h40;
      step(); step();
      rst_n = 0; i_req = 0;
      step();
      rst_n = 1;
      check("mid busy", 32'(busy), 0);
      check("mid i_fills", i_fills, 0);
      check("mid d_fills", d_fills, 0);
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (i_valid || d_valid) seen++;
      end
      check("mid no pulse", 32'(seen), 0);
      i_req = 1; i_add = 32'h1234;
      wait_fill(20, k, b1);
      check("mid next lat", 32'(k), 4);
      check("mid next w0", i_data[31:0], 32'h1200);
      i_req = 0;
      step();
      check("mid next fills", i_fills, 1);

      // Fill counter wrap.
      force u4.i_fills = 32'hFFFF_FFFF;
      #1;
      release u4.i_fills;
      i_req = 1; i_add = 32'h80;
      wait_fill(20, k, b1);
      check("wrap valid", 32'(i_valid), 1);
      i_req = 0;
      step();
      check("wrap i_fills", i_fills, 0);
      check("wrap d_fills", d_fills, 0);

      // LATENCY=1 instance with a line at the top of the address space.
      d_req1 = 1; d_add1 = 32'hFFFF_FFC4;
      step();
      check("l1 d_valid", 32'(d_valid1), 1);
      check("l1 i_valid", 32'(i_valid1), 0);
      check("l1 w0", d_data1[31:0], 32'hFFFF_FFC0);
      check("l1 w15", d_data1[511:480], 32'hFFFF_FFFC);
      d_req1 = 0;
      step();
      check("l1 pulse", 32'(d_valid1), 0);
      check("l1 d_fills", d_fills1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
